stream_downsizer: RTL and testbench

Width-converting stage placed directly downstream of a relay station. It accepts one `PAYLOAD_BITS`-wide word over the val/ready handshake and emits it as `RATIO = PAYLOAD_BITS/FLIT_BITS` narrower flits, LSB slice first, to a narrower overlay link. Sustained throughput is one flit per cycle, with no bubble between consecutive words.

---
 rtl/stream_pkg.sv | 27 ++
 rtl/stream_downsizer.sv | 90 +++++++++
 tb/tb_stream_downsizer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for stream width converters: FSM state encoding and
// elaboration-time helpers for slice counts and counter widths.
package stream_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Number of narrow slices per wide word; upsizers use the same relation.
  function automatic int ratio(input int wide_bits, input int narrow_bits);
    return wide_bits / narrow_bits;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Splits one PAYLOAD_BITS word into RATIO flits, LSB slice first, at one flit per cycle.
// Optional last_out flag is built when STREAM_DOWNSIZER_LAST_EN is defined.
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int FLIT_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    val_in,
  input  logic [PAYLOAD_BITS-1:0] din,
  output logic                    ready_upward,
  output logic                    val_out,
  output logic [FLIT_BITS-1:0]    dout,
  input  logic                    ready_downward
`ifdef STREAM_DOWNSIZER_LAST_EN
  ,
  output logic                    last_out
`endif
);

  localparam int RATIO = ratio(PAYLOAD_BITS, FLIT_BITS);
  localparam int CNT_W = clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  if ((PAYLOAD_BITS % FLIT_BITS) != 0 || RATIO < 2) begin : g_param_check
    $error("stream_downsizer: FLIT_BITS must divide PAYLOAD_BITS with a ratio of at least 2");
  end

  state_t                  state, state_n;
  logic [PAYLOAD_BITS-1:0] data_buf, data_buf_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    last_beat;

  assign last_beat = (state == ST_SEND) && (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      data_buf <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      data_buf <= data_buf_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    data_buf_n = data_buf;
    cnt_n      = cnt;
    case (state)
      ST_IDLE: begin
        if (val_in) begin
          data_buf_n = din;
          cnt_n      = '0;
          state_n    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ready_downward) begin
          if (cnt != LAST_BEAT) begin
            data_buf_n = data_buf >> FLIT_BITS;
            cnt_n      = cnt + CNT_W'(1);
          end else if (val_in) begin
            // Reload on the final beat so consecutive words leave no bubble.
            data_buf_n = din;
            cnt_n      = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // ready_upward combinationally follows ready_downward on the last beat;
  // the upstream relay station breaks that path.
  assign ready_upward = !reset && ((state == ST_IDLE) || (last_beat && ready_downward));
  assign val_out      = !reset && (state == ST_SEND);
  assign dout         = reset ? '0 : data_buf[FLIT_BITS-1:0];

`ifdef STREAM_DOWNSIZER_LAST_EN
  assign last_out = !reset && last_beat;
`endif

endmodule

// File: tb/tb_stream_downsizer.sv
// Self-checking bench for stream_downsizer: directed scenarios on 32->8 and 32->16
// instances, plus a randomized run against a flit-queue reference model.
module tb_stream_downsizer;

  logic        clk;
  logic        reset;
  logic        val_in;
  logic [31:0] din;
  logic        ready_downward;

  logic        ready_upward, val_out;
  logic [7:0]  dout;
  logic        ready_upward_w, val_out_w;
  logic [15:0] dout_w;
`ifdef STREAM_DOWNSIZER_LAST_EN
  logic        last_out, last_out_w;
`endif

  int total = 0;
  int bad   = 0;

  stream_downsizer #(.PAYLOAD_BITS(32), .FLIT_BITS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .val_in         (val_in),
    .din            (din),
    .ready_upward   (ready_upward),
    .val_out        (val_out),
    .dout           (dout),
    .ready_downward (ready_downward)
`ifdef STREAM_DOWNSIZER_LAST_EN
    ,
    .last_out       (last_out)
`endif
  );

  stream_downsizer #(.PAYLOAD_BITS(32), .FLIT_BITS(16)) dut_wide (
    .clk            (clk),
    .reset          (reset),
    .val_in         (val_in),
    .din            (din),
    .ready_upward   (ready_upward_w),
    .val_out        (val_out_w),
    .dout           (dout_w),
    .ready_downward (ready_downward)
`ifdef STREAM_DOWNSIZER_LAST_EN
    ,
    .last_out       (last_out_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then settle so outputs can be sampled.
  task automatic cyc(input logic v, input logic [31:0] d, input logic rd);
    @(negedge clk);
    val_in = v;
    din = d;
    ready_downward = rd;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    val_in = 1'b0;
    din = '0;
    ready_downward = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (val_out !== 1'b0 || ready_upward !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: got val_out=%b ready_upward=%b dout=%h want 0 0 00", val_out, ready_upward, dout);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (ready_upward !== 1'b1 || val_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready_upward=%b val_out=%b want 1 0", ready_upward, val_out);
    end
  endtask

  task automatic test_single();
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    cyc(1'b1, w, 1'b1);
    total++;
    if (ready_upward !== 1'b1 || val_out !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: got ready_upward=%b val_out=%b want 1 0", ready_upward, val_out);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      total++;
      if (val_out !== 1'b1 || dout !== w[8*i +: 8] || ready_upward !== (i == 3)) begin
        bad++;
        $display("FAIL single_beat%0d: got val=%b dout=%h ru=%b want 1 %h %b", i, val_out, dout, ready_upward, w[8*i +: 8], (i == 3));
      end
`ifdef STREAM_DOWNSIZER_LAST_EN
      total++;
      if (last_out !== (i == 3)) begin
        bad++;
        $display("FAIL single_last%0d: got %b want %b", i, last_out, (i == 3));
      end
`endif
    end
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (val_out !== 1'b0) begin
      bad++;
      $display("FAIL single_after: got val_out=%b want 0", val_out);
    end
  endtask

  task automatic test_wide_flit();
    logic [31:0] w;
    w = 32'hCAFEF00D;
    cyc(1'b1, w, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'h0, 1'b1);
      total++;
      if (val_out_w !== 1'b1 || dout_w !== w[16*i +: 16]) begin
        bad++;
        $display("FAIL wide_beat%0d: got val=%b dout=%h want 1 %h", i, val_out_w, dout_w, w[16*i +: 16]);
      end
`ifdef STREAM_DOWNSIZER_LAST_EN
      total++;
      if (last_out_w !== (i == 1)) begin
        bad++;
        $display("FAIL wide_last%0d: got %b want %b", i, last_out_w, (i == 1));
      end
`endif
    end
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (val_out_w !== 1'b0) begin
      bad++;
      $display("FAIL wide_after: got val_out=%b want 0", val_out_w);
    end
    repeat (3) cyc(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] pair;
    pair = {32'h55667788, 32'h11223344};
    cyc(1'b1, pair[31:0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) cyc(1'b1, pair[63:32], 1'b1);
      else       cyc(1'b0, 32'h0, 1'b1);
      total++;
      if (val_out !== 1'b1 || dout !== pair[8*i +: 8] || ready_upward !== ((i % 4) == 3)) begin
        bad++;
        $display("FAIL b2b_beat%0d: got val=%b dout=%h ru=%b want 1 %h %b", i, val_out, dout, ready_upward, pair[8*i +: 8], ((i % 4) == 3));
      end
    end
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (val_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after: got val_out=%b want 0", val_out);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic [7:0]  exp_flit [0:6];
    logic        rd_seq   [0:6];
    w = 32'hA1B2C3D4;
    exp_flit = '{8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hB2, 8'hA1};
    rd_seq   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cyc(1'b1, w, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 32'h0, rd_seq[i]);
      total++;
      if (val_out !== 1'b1 || dout !== exp_flit[i] || ready_upward !== (i == 6)) begin
        bad++;
        $display("FAIL bp_beat%0d: got val=%b dout=%h ru=%b want 1 %h %b", i, val_out, dout, ready_upward, exp_flit[i], (i == 6));
      end
    end
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (val_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_after: got val_out=%b want 0", val_out);
    end
  endtask

  task automatic test_reset_mid_word();
    cyc(1'b1, 32'hA1B2C3D4, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (dout !== 8'hD4) begin
      bad++;
      $display("FAIL rmw_first: got dout=%h want d4", dout);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    #1;
    total++;
    if (val_out !== 1'b0) begin
      bad++;
      $display("FAIL rmw_in_reset: got val_out=%b want 0", val_out);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (val_out !== 1'b0 || ready_upward !== 1'b1) begin
      bad++;
      $display("FAIL rmw_release: got val_out=%b ru=%b want 0 1", val_out, ready_upward);
    end
    cyc(1'b1, 32'hDEADBEEF, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (val_out !== 1'b1 || dout !== 8'hEF) begin
      bad++;
      $display("FAIL rmw_new_word: got val=%b dout=%h want 1 ef", val_out, dout);
    end
    repeat (4) cyc(1'b0, 32'h0, 1'b1);
  endtask

  // Reference: a queue of flits still owed downstream. A word is taken when the
  // queue is empty or its final flit leaves this cycle; flits leave in order.
  task automatic test_random();
    logic [7:0]  pend [$];
    logic        exp_val, exp_ru, rd;
    logic [31:0] w;
    int          words_in, flits_out;
    words_in = 0;
    flits_out = 0;
    for (int c = 0; c < 600; c++) begin
      rd = ($urandom_range(0, 3) != 0);
      w  = $urandom;
      cyc(($urandom_range(0, 2) != 0), w, rd);
      exp_val = (pend.size() != 0);
      exp_ru  = (pend.size() == 0) || (pend.size() == 1 && rd);
      total++;
      if (val_out !== exp_val || ready_upward !== exp_ru) begin
        bad++;
        $display("FAIL rand_handshake c%0d: got val=%b ru=%b want %b %b", c, val_out, ready_upward, exp_val, exp_ru);
      end
      if (exp_val) begin
        total++;
        if (dout !== pend[0]) begin
          bad++;
          $display("FAIL rand_flit c%0d: got %h want %h", c, dout, pend[0]);
        end
`ifdef STREAM_DOWNSIZER_LAST_EN
        total++;
        if (last_out !== (pend.size() == 1)) begin
          bad++;
          $display("FAIL rand_last c%0d: got %b want %b", c, last_out, (pend.size() == 1));
        end
`endif
      end
      if (exp_val && rd) begin
        void'(pend.pop_front());
        flits_out++;
      end
      if (val_in && exp_ru) begin
        for (int k = 0; k < 4; k++) pend.push_back(w[8*k +: 8]);
        words_in++;
      end
    end
    for (int c = 0; c < 8 && pend.size() != 0; c++) begin
      cyc(1'b0, 32'h0, 1'b1);
      total++;
      if (val_out !== 1'b1 || dout !== pend[0]) begin
        bad++;
        $display("FAIL rand_drain c%0d: got val=%b dout=%h want 1 %h", c, val_out, dout, pend[0]);
      end
      void'(pend.pop_front());
      flits_out++;
    end
    cyc(1'b0, 32'h0, 1'b1);
    total++;
    if (val_out !== 1'b0 || flits_out != 4 * words_in) begin
      bad++;
      $display("FAIL rand_end: got val=%b flits=%0d want 0 %0d", val_out, flits_out, 4 * words_in);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wide_flit();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
